fruit_spawner: RTL and testbench
================================

FRUIT_SPAWNER -- requirements
Module: fruit_spawner

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value; 0 SHALL be replaced by 16'h0001.
REQ-002 The block SHALL have parameter MIN_DELAY, default 30, meaning the minimum frames between a fruit leaving and the next spawn.
REQ-003 The block SHALL have parameter X_MIN, default 64, meaning the leftmost spawn X.
REQ-004 The block SHALL have parameter VY_BASE, default 12, meaning the minimum upward launch speed.
REQ-005 The block SHALL have port frame_clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: game running.
REQ-008 The block SHALL have port fruit_ack, input, 1 bit: the fruit has loaded the spawn values.
REQ-009 The block SHALL have port fruit_gone, input, 1 bit: the fruit left the screen or was sliced.
REQ-010 The block SHALL have port newfruit, output, 1 bit: spawn request.
REQ-011 The block SHALL have port spawn_x, output, 10 bits: launch X, unsigned.
REQ-012 The block SHALL have port spawn_vx, output, 10 bits: X velocity, two's complement.
REQ-013 The block SHALL have port spawn_vy, output, 10 bits: Y velocity, two's complement; negative means upward.
REQ-014 The block SHALL have port spawn_type, output, 2 bits: fruit kind.
REQ-015 The block SHALL have port spawn_count, output, 8 bits: spawns completed.
REQ-016 All outputs SHALL be driven from registers.

Function
REQ-017 The 16-bit LFSR SHALL advance on every frame_clk edge while out of reset.
- Feedback: fb = l[15]^l[13]^l[12]^l[10].
- Update: l <= {l[14:0], fb}.
- Every use of l below reads the pre-edge value.
REQ-018 The FSM SHALL have four states: IDLE, WAIT, REQ, FLIGHT. newfruit SHALL be 1 exactly when the state is REQ.
REQ-019 IDLE: when enable=1, the block SHALL go to WAIT and load cnt <= MIN_DELAY + l[4:0]; otherwise it SHALL stay in IDLE.
REQ-020 WAIT with enable=1 and cnt!=0: cnt SHALL decrement.
REQ-021 WAIT with enable=1 and cnt==0: the block SHALL go to REQ and latch spawn outputs from l in that same edge (REQ-024..027).
REQ-022 WAIT with enable=0: cnt SHALL freeze and the state SHALL hold.
REQ-023 The cnt register SHALL be 7 bits wide; MIN_DELAY SHALL be at most 96.
REQ-024 spawn_x SHALL be X_MIN + l[8:0], giving a range of 64..575.
REQ-025 Let mag = 1 + l[10:9] (range 1..4). spawn_vx SHALL be +mag if spawn_x < 320, else -mag.
REQ-026 spawn_vy SHALL be -(VY_BASE + l[12:11]), in 10-bit two's complement (for example, -12 = 10'h3F4).
REQ-027 spawn_type SHALL be l[14:13].
REQ-028 REQ: spawn outputs SHALL hold stable; newfruit SHALL stay high until fruit_ack=1 is sampled.
REQ-029 When fruit_ack=1 is sampled in REQ, the block SHALL go to FLIGHT and spawn_count SHALL increment, wrapping 255 to 0.
REQ-030 In REQ, enable=0 SHALL NOT abort the request.
REQ-031 FLIGHT: when fruit_gone=1, the block SHALL go to WAIT (reloading cnt per REQ-019) if enable=1, else to IDLE.
REQ-032 fruit_gone SHALL be ignored outside FLIGHT; fruit_ack SHALL be ignored outside REQ.
REQ-033 If fruit_ack and fruit_gone are both 1 in the same REQ cycle, the block SHALL take only the ack and enter FLIGHT; the gone SHALL be dropped.
REQ-034 Between requests, the spawn outputs SHALL retain their last latched values.

Reset
REQ-035 Reset_n=0 SHALL immediately (asynchronously) force:
- state to IDLE;
- newfruit, spawn_x, spawn_vx, spawn_vy, spawn_type and spawn_count to 0;
- cnt to 0;
- l to SEED.
REQ-036 A reset in any state, including mid-REQ, SHALL abandon the request without requiring fruit_ack.
REQ-037 Release of Reset_n SHALL be sampled synchronously; the first state change SHALL occur on the first edge after release.

Verification
REQ-038 Reset value: Reset_n low, then released, with enable=0 for 10 edges -> newfruit=0, spawn_count=0, state IDLE, all spawn outputs 0.
REQ-039 First-spawn latency: SEED=ACE1, enable=1 from the first edge after release (E0) -> cnt=31 after E0, newfruit rises after E32, and the spawn fields match a bench LFSR model.
REQ-040 Handshake hold: keep fruit_ack=0 for 50 cycles in REQ -> newfruit and all spawn fields remain constant; on ack, newfruit falls and spawn_count=1.
REQ-041 Pause: drop enable for 20 cycles while in WAIT -> cnt frozen, and newfruit is delayed by exactly 20 cycles versus the unpaused run.
REQ-042 Flight exit: fruit_gone with enable=1 returns to WAIT; with enable=0 it returns to IDLE; fruit_gone pulses in WAIT or REQ change nothing. Simultaneous ack+gone in REQ -> FLIGHT.
REQ-043 Range sweep: 300 spawns checking spawn_x in 64..575, the vx sign versus the 320 threshold, vy in -15..-12, and spawn_count wrapping to 44 after 300 spawns; assert Reset_n mid-REQ -> newfruit=0 asynchronously.

Source files
------------

// File: rtl/fruit_spawner.sv
// fruit_spawner: decides when and where the next fruit is launched.
// A free-running 16-bit LFSR supplies a random inter-spawn delay and the
// launch parameters. The block waits, raises a spawn request, holds it until
// the fruit accepts the values, then waits for that fruit to leave the screen.
//
// Ports
//   frame_clk    in   1   single clock, rising edge
//   Reset_n      in   1   asynchronous active-low reset
//   enable       in   1   game running
//   fruit_ack    in   1   fruit has loaded the spawn values
//   fruit_gone   in   1   fruit left the screen or was sliced
//   newfruit     out  1   spawn request, high while waiting for fruit_ack
//   spawn_x      out  10  launch X, unsigned
//   spawn_vx     out  10  X velocity, two's complement
//   spawn_vy     out  10  Y velocity, two's complement, negative is upward
//   spawn_type   out  2   fruit kind
//   spawn_count  out  8   spawns completed, wraps at 256
//
// Parameters
//   SEED       LFSR reset value (0 is replaced by 16'h0001)
//   MIN_DELAY  minimum frames between a fruit leaving and the next spawn (<= 96)
//   X_MIN      leftmost spawn X
//   VY_BASE    minimum upward launch speed
module fruit_spawner #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MIN_DELAY = 30,
  parameter int unsigned X_MIN     = 64,
  parameter int unsigned VY_BASE   = 12
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       enable,
  input  logic       fruit_ack,
  input  logic       fruit_gone,
  output logic       newfruit,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_vx,
  output logic [9:0] spawn_vy,
  output logic [1:0] spawn_type,
  output logic [7:0] spawn_count
);

  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned CNT_OUT_W = 8;

  // An all-zero seed would lock the LFSR up, so it is forced to 1.
  localparam logic [LFSR_W-1:0]  SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // Fruit spawned left of screen centre drift right, others drift left.
  localparam logic [COORD_W-1:0] X_CENTRE = COORD_W'(320);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_FLIGHT
  } state_t;

  state_t              state;
  logic [LFSR_W-1:0]   lfsr;
  logic [CNT_W-1:0]    cnt;

  logic                lfsr_fb;
  logic [CNT_W-1:0]    cnt_load;
  logic [COORD_W-1:0]  x_new;
  logic [COORD_W-1:0]  vx_mag;
  logic [COORD_W-1:0]  vx_new;
  logic [COORD_W-1:0]  vy_new;

  // Next LFSR bit, reload delay and candidate spawn values from the current LFSR.
  always_comb begin
    lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // MIN_DELAY <= 96 keeps MIN_DELAY + 31 inside the 7-bit counter.
    cnt_load = CNT_W'(MIN_DELAY) + CNT_W'(lfsr[4:0]);
    x_new    = COORD_W'(X_MIN) + COORD_W'(lfsr[8:0]);
    vx_mag   = COORD_W'(lfsr[10:9]) + COORD_W'(1);
    vx_new   = (x_new < X_CENTRE) ? vx_mag : (COORD_W'(0) - vx_mag);
    vy_new   = COORD_W'(0) - (COORD_W'(VY_BASE) + COORD_W'(lfsr[12:11]));
  end

  // LFSR, spawn FSM and registered outputs.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      lfsr        <= SEED_EFF;
      cnt         <= '0;
      newfruit    <= 1'b0;
      spawn_x     <= '0;
      spawn_vx    <= '0;
      spawn_vy    <= '0;
      spawn_type  <= '0;
      spawn_count <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};

      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_WAIT;
            cnt   <= cnt_load;
          end
        end

        // Counter and state both freeze while the game is paused.
        S_WAIT: begin
          if (enable) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state      <= S_REQ;
              newfruit   <= 1'b1;
              spawn_x    <= x_new;
              spawn_vx   <= vx_new;
              spawn_vy   <= vy_new;
              spawn_type <= lfsr[14:13];
            end
          end
        end

        // A request is never aborted by enable; only the ack (or reset) ends it.
        // A fruit_gone arriving with the ack is dropped.
        S_REQ: begin
          if (fruit_ack) begin
            state       <= S_FLIGHT;
            newfruit    <= 1'b0;
            spawn_count <= spawn_count + CNT_OUT_W'(1);
          end
        end

        S_FLIGHT: begin
          if (fruit_gone) begin
            if (enable) begin
              state <= S_WAIT;
              cnt   <= cnt_load;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          newfruit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_spawner.sv
// Directed testbench for fruit_spawner with default parameters.
module tb_fruit_spawner;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       enable;
  logic       fruit_ack;
  logic       fruit_gone;
  logic       newfruit;
  logic [9:0] spawn_x;
  logic [9:0] spawn_vx;
  logic [9:0] spawn_vy;
  logic [1:0] spawn_type;
  logic [7:0] spawn_count;

  int checks   = 0;
  int failures = 0;

  // Reference LFSR: m_prev holds the value the DUT saw before the latest edge.
  logic [15:0] m_l;
  logic [15:0] m_prev;

  always #5 frame_clk = ~frame_clk;

  fruit_spawner dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .enable     (enable),
    .fruit_ack  (fruit_ack),
    .fruit_gone (fruit_gone),
    .newfruit   (newfruit),
    .spawn_x    (spawn_x),
    .spawn_vx   (spawn_vx),
    .spawn_vy   (spawn_vy),
    .spawn_type (spawn_type),
    .spawn_count(spawn_count)
  );

  always @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_l    <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_l;
      m_l    <= {m_l[14:0], m_l[15] ^ m_l[13] ^ m_l[12] ^ m_l[10]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Expected {x, vx, vy, type} for a given pre-edge LFSR value.
  function automatic logic [31:0] exp_fields(input logic [15:0] l);
    logic [9:0] x, mag, vx, vy;
    x   = 10'd64 + {1'b0, l[8:0]};
    mag = 10'd1 + {8'd0, l[10:9]};
    vx  = (x < 10'd320) ? mag : (10'd0 - mag);
    vy  = 10'd0 - (10'd12 + {8'd0, l[12:11]});
    return {x, vx, vy, l[14:13]};
  endfunction

  function automatic logic [31:0] obs_fields();
    return {spawn_x, spawn_vx, spawn_vy, spawn_type};
  endfunction

  // Advance until newfruit is seen, returning the number of edges taken.
  task automatic wait_rise(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!newfruit && n < 400);
    chk(tag, 32'(newfruit), 32'd1);
  endtask

  int          n;
  int          k;
  int          c;
  logic [31:0] held;
  logic        ok;

  initial begin
    Reset_n    = 1'b0;
    enable     = 1'b0;
    fruit_ack  = 1'b0;
    fruit_gone = 1'b0;

    // Reset values while held, then ten idle edges with enable low.
    #2;
    chk("rst_newfruit", 32'(newfruit), 32'd0);
    chk("rst_count", 32'(spawn_count), 32'd0);
    chk("rst_fields", obs_fields(), 32'd0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    repeat (10) tick();
    chk("idle_newfruit", 32'(newfruit), 32'd0);
    chk("idle_count", 32'(spawn_count), 32'd0);
    chk("idle_fields", obs_fields(), 32'd0);

    // First spawn: cnt = 30 + 1 = 31 after E0, request rises on E32 (33rd edge).
    Reset_n = 1'b0;
    #2;
    enable  = 1'b1;
    Reset_n = 1'b1;
    wait_rise("first_rise", n);
    chk("first_latency", 32'(n), 32'd33);
    chk("first_fields", obs_fields(), exp_fields(m_prev));

    // Request holds for 50 cycles without ack.
    held = obs_fields();
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_newfruit", 32'(newfruit), 32'd1);
      chk("hold_fields", obs_fields(), held);
    end
    fruit_ack = 1'b1;
    tick();
    fruit_ack = 1'b0;
    chk("ack_newfruit", 32'(newfruit), 32'd0);
    chk("ack_count", 32'(spawn_count), 32'd1);
    chk("ack_fields_kept", obs_fields(), held);

    // Ack in FLIGHT is ignored.
    fruit_ack = 1'b1;
    tick();
    fruit_ack = 1'b0;
    chk("flight_ack_count", 32'(spawn_count), 32'd1);
    chk("flight_ack_newfruit", 32'(newfruit), 32'd0);

    // Gone with enable=1 -> WAIT; 20-edge pause and a stray gone pulse in WAIT.
    fruit_gone = 1'b1;
    tick();
    fruit_gone = 1'b0;
    c = 30 + int'(m_prev[4:0]);
    k = 0;
    while (k < 400) begin
      tick();
      k++;
      if (newfruit) break;
      enable     = !(k >= 5 && k < 25);
      fruit_gone = (k == 3);
    end
    enable     = 1'b1;
    fruit_gone = 1'b0;
    chk("pause_rise", 32'(newfruit), 32'd1);
    chk("pause_latency", 32'(k), 32'(c + 21));
    chk("pause_fields", obs_fields(), exp_fields(m_prev));

    // In REQ: gone pulse and enable=0 change nothing.
    enable     = 1'b0;
    fruit_gone = 1'b1;
    tick();
    fruit_gone = 1'b0;
    repeat (3) tick();
    chk("req_gone_newfruit", 32'(newfruit), 32'd1);
    chk("req_gone_count", 32'(spawn_count), 32'd1);

    // Simultaneous ack+gone: only the ack is taken, fruit stays in flight.
    fruit_ack  = 1'b1;
    fruit_gone = 1'b1;
    tick();
    fruit_ack  = 1'b0;
    fruit_gone = 1'b0;
    chk("both_newfruit", 32'(newfruit), 32'd0);
    chk("both_count", 32'(spawn_count), 32'd2);
    enable = 1'b1;
    repeat (140) tick();
    chk("both_stays_flight", 32'(newfruit), 32'd0);

    // Gone with enable=0 -> IDLE; re-enable reloads the delay from scratch.
    enable     = 1'b0;
    fruit_gone = 1'b1;
    tick();
    fruit_gone = 1'b0;
    repeat (140) tick();
    chk("idle_after_gone", 32'(newfruit), 32'd0);
    enable = 1'b1;
    tick();
    c = 30 + int'(m_prev[4:0]);
    wait_rise("idle_rise", n);
    chk("idle_latency", 32'(n), 32'(c + 1));
    chk("idle_fields", obs_fields(), exp_fields(m_prev));

    // Range sweep over 300 spawns from a fresh reset.
    Reset_n = 1'b0;
    #2;
    chk("sweep_rst_count", 32'(spawn_count), 32'd0);
    chk("sweep_rst_newfruit", 32'(newfruit), 32'd0);
    Reset_n = 1'b1;
    for (int s = 0; s < 300; s++) begin
      wait_rise("sweep_rise", n);
      chk("sweep_fields", obs_fields(), exp_fields(m_prev));
      chk("sweep_x_range", 32'(spawn_x >= 10'd64 && spawn_x <= 10'd575), 32'd1);
      ok = (spawn_x < 10'd320) ? (spawn_vx >= 10'd1 && spawn_vx <= 10'd4)
                               : (spawn_vx >= 10'h3FC && spawn_vx <= 10'h3FF);
      chk("sweep_vx_sign", 32'(ok), 32'd1);
      chk("sweep_vy_range", 32'(spawn_vy >= 10'h3F1 && spawn_vy <= 10'h3F4), 32'd1);
      fruit_ack = 1'b1;
      tick();
      fruit_ack  = 1'b0;
      fruit_gone = 1'b1;
      tick();
      fruit_gone = 1'b0;
    end
    chk("sweep_count_wrap", 32'(spawn_count), 32'd44);

    // Reset mid-REQ drops the request asynchronously.
    wait_rise("midreq_rise", n);
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midreq_newfruit", 32'(newfruit), 32'd0);
    chk("midreq_count", 32'(spawn_count), 32'd0);
    chk("midreq_fields", obs_fields(), 32'd0);
    #10;
    Reset_n = 1'b1;
    enable  = 1'b0;
    repeat (3) tick();
    chk("after_reset_idle", 32'(newfruit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
